// File: rtl/seq_mult_pkg.sv
// Shared types for the shift-add sequential multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_mult_core_if.sv
// Start/abort/operand request and busy/done/product response bundle.
interface seq_mult_core_if #(parameter int WIDTH = 4);

  logic                 start;
  logic                 abort;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (output start, abort, multiplicand, multiplier,
                  input  busy, done, product);
  modport slave  (input  start, abort, multiplicand, multiplier,
                  output busy, done, product);

endinterface

// File: rtl/mult_acc_reg.sv
// {C,H,L} accumulator: clear, load multiplier into L, or conditional add of M then shift right.
module mult_acc_reg #(parameter int WIDTH = 4) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic               add_shift_i,
  input  logic [WIDTH-1:0]   operand_i,
  input  logic [WIDTH-1:0]   m_i,
  output logic [2*WIDTH-1:0] hl_d_o
);

  logic             c_q;
  logic [WIDTH-1:0] h_q, l_q;
  logic [WIDTH:0]   sum;

  // C is always 0 after a shift, so folding it into the add is harmless
  assign sum    = {c_q, h_q} + (l_q[0] ? {1'b0, m_i} : '0);
  assign hl_d_o = {sum, l_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      c_q <= 1'b0;
      h_q <= '0;
      l_q <= '0;
    end else if (clear_i) begin
      c_q <= 1'b0;
      h_q <= '0;
      l_q <= '0;
    end else if (load_i) begin
      c_q <= 1'b0;
      h_q <= '0;
      l_q <= operand_i;
    end else if (add_shift_i) begin
      c_q          <= 1'b0;
      {h_q, l_q}   <= hl_d_o;
    end
  end

endmodule

// File: rtl/seq_mult_core.sv
// Unsigned shift-add multiplier: one 2*WIDTH product per WIDTH+1 cycles, with synchronous abort.
module seq_mult_core
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic            clk,
  input logic            clr_n,
  seq_mult_core_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     m_q;
  logic [2*WIDTH-1:0]   product_q, hl_d;
  logic                 busy_q, done_q;
  logic                 load, add_shift;

  assign load      = bus.start && !bus.abort && (state_q == ST_IDLE || state_q == ST_DONE);
  assign add_shift = (state_q == ST_RUN) && !bus.abort;

  mult_acc_reg #(.WIDTH(WIDTH)) u_acc (
    .clk         (clk),
    .clr_n       (clr_n),
    .clear_i     (bus.abort),
    .load_i      (load),
    .add_shift_i (add_shift),
    .operand_i   (bus.multiplier),
    .m_i         (m_q),
    .hl_d_o      (hl_d)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      m_q       <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (bus.abort) begin
      // product is deliberately kept; only the in-flight operation is dropped
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            m_q     <= bus.multiplicand;
            cnt_q   <= CNT_W'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            product_q <= hl_d;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= ST_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_seq_mult_core.sv
// Bench for seq_mult_core at WIDTH=4 and WIDTH=8 against a plain-multiply reference.
module tb_seq_mult_core;

  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  seq_mult_core_if #(.WIDTH(4)) a4 ();
  seq_mult_core_if #(.WIDTH(8)) a8 ();

  seq_mult_core #(.WIDTH(4)) u4 (.clk(clk), .clr_n(clr_n), .bus(a4));
  seq_mult_core #(.WIDTH(8)) u8 (.clk(clk), .clr_n(clr_n), .bus(a8));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] m;
    logic [3:0] q;
    logic [7:0] p;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One transaction on the WIDTH=4 unit; called at a negedge with the unit idle.
  task automatic op4(input logic [3:0] m, input logic [3:0] q, input logic [7:0] exp, input string tag);
    int k, nb;
    a4.start = 1'b1; a4.multiplicand = m; a4.multiplier = q;
    @(negedge clk);
    a4.start = 1'b0;
    k = 0; nb = 0;
    while (!a4.done && k < 40) begin
      if (a4.busy) nb++;
      @(negedge clk); k++;
    end
    check({tag, " latency"}, 64'(k), 64'd4);
    check({tag, " busy cycles"}, 64'(nb), 64'd4);
    check({tag, " product"}, 64'(a4.product), 64'(exp));
    check({tag, " busy with done"}, 64'(a4.busy), 64'd0);
    @(negedge clk);
    check({tag, " done pulse width"}, 64'(a4.done), 64'd0);
    check({tag, " product held"}, 64'(a4.product), 64'(exp));
  endtask

  task automatic op8(input logic [7:0] m, input logic [7:0] q, input logic [15:0] exp, input string tag);
    int k, nb;
    a8.start = 1'b1; a8.multiplicand = m; a8.multiplier = q;
    @(negedge clk);
    a8.start = 1'b0;
    k = 0; nb = 0;
    while (!a8.done && k < 40) begin
      if (a8.busy) nb++;
      @(negedge clk); k++;
    end
    check({tag, " latency"}, 64'(k), 64'd8);
    check({tag, " busy cycles"}, 64'(nb), 64'd8);
    check({tag, " product"}, 64'(a8.product), 64'(exp));
    @(negedge clk);
    check({tag, " done pulse width"}, 64'(a8.done), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, gap;
    logic [7:0]  pm, rm4, rq4;
    logic [15:0] rm8, rq8;

    vecs[0] = '{4'd13, 4'd11, 8'h8F};
    vecs[1] = '{4'd15, 4'd15, 8'hE1};
    vecs[2] = '{4'd0,  4'd9,  8'h00};
    vecs[3] = '{4'd9,  4'd0,  8'h00};
    vecs[4] = '{4'd6,  4'd7,  8'd42};
    vecs[5] = '{4'd1,  4'd15, 8'd15};
    vecs[6] = '{4'd15, 4'd1,  8'd15};
    vecs[7] = '{4'd8,  4'd8,  8'd64};

    clr_n = 1'b0;
    a4.start = 1'b0; a4.abort = 1'b0; a4.multiplicand = '0; a4.multiplier = '0;
    a8.start = 1'b0; a8.abort = 1'b0; a8.multiplicand = '0; a8.multiplier = '0;
    #12;
    check("reset product4", 64'(a4.product), 64'd0);
    check("reset busy4", 64'(a4.busy), 64'd0);
    check("reset done4", 64'(a4.done), 64'd0);
    check("reset product8", 64'(a8.product), 64'd0);
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      op4(vecs[i].m, vecs[i].q, vecs[i].p, $sformatf("vec%0d", i));

    // back-to-back: start held through DONE carries the second pair
    a4.start = 1'b1; a4.multiplicand = 4'd13; a4.multiplier = 4'd11;
    @(negedge clk);
    a4.multiplicand = 4'd6; a4.multiplier = 4'd7;
    nd = 0;
    while (!a4.done && nd < 40) begin @(negedge clk); nd++; end
    check("b2b first product", 64'(a4.product), 64'h8F);
    gap = 0;
    @(negedge clk); gap++;
    a4.start = 1'b0;
    check("b2b done falls", 64'(a4.done), 64'd0);
    check("b2b second busy", 64'(a4.busy), 64'd1);
    while (!a4.done && gap < 40) begin @(negedge clk); gap++; end
    check("b2b gap", 64'(gap), 64'd5);
    check("b2b second product", 64'(a4.product), 64'd42);
    @(negedge clk);

    // start pulsed mid-RUN is ignored
    a4.start = 1'b1; a4.multiplicand = 4'd3; a4.multiplier = 4'd5;
    @(negedge clk); a4.start = 1'b0;
    @(negedge clk); a4.start = 1'b1; a4.multiplicand = 4'd2; a4.multiplier = 4'd2;
    @(negedge clk); a4.start = 1'b0;
    nd = 0; pm = '0;
    repeat (12) begin
      @(negedge clk);
      if (a4.done) begin nd++; pm = a4.product; end
    end
    check("mid-run start done count", 64'(nd), 64'd1);
    check("mid-run start product", 64'(pm), 64'd15);

    // abort in RUN cycle 2 keeps the previous product
    op4(4'd5, 4'd3, 8'd15, "pre-abort");
    a4.start = 1'b1; a4.multiplicand = 4'd7; a4.multiplier = 4'd7;
    @(negedge clk); a4.start = 1'b0;
    @(negedge clk); a4.abort = 1'b1;
    @(negedge clk); a4.abort = 1'b0;
    check("abort busy", 64'(a4.busy), 64'd0);
    check("abort done", 64'(a4.done), 64'd0);
    nd = 0;
    repeat (10) begin @(negedge clk); if (a4.done) nd++; end
    check("abort no done", 64'(nd), 64'd0);
    check("abort product kept", 64'(a4.product), 64'd15);

    // asynchronous clear mid-RUN
    a4.start = 1'b1; a4.multiplicand = 4'd9; a4.multiplier = 4'd9;
    @(negedge clk); a4.start = 1'b0;
    @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    check("async clr product", 64'(a4.product), 64'd0);
    check("async clr busy", 64'(a4.busy), 64'd0);
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    op4(4'd9, 4'd9, 8'd81, "post-clr");

    op8(8'd255, 8'd255, 16'hFE01, "w8 max");
    op8(8'd0, 8'd200, 16'd0, "w8 zero");

    for (int i = 0; i < 200; i++) begin
      rm4 = 8'($urandom_range(0, 15));
      rq4 = 8'($urandom_range(0, 15));
      op4(rm4[3:0], rq4[3:0], 8'(rm4 * rq4), $sformatf("rand4 %0d*%0d", rm4, rq4));
    end
    for (int i = 0; i < 1000; i++) begin
      rm8 = 16'($urandom_range(0, 255));
      rq8 = 16'($urandom_range(0, 255));
      op8(rm8[7:0], rq8[7:0], rm8 * rq8, $sformatf("rand8 %0d*%0d", rm8, rq8));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
